// File: rtl/preem_delay_mult.sv
// Pre-emphasis feed stage: presents x[n] with round(a*x[n-1]) one pipeline step later.
// Optional build macro PREEM_COEF_PROG_EN adds a run-time loadable coefficient register.
`default_nettype none

module preem_delay_mult #(
  parameter logic [15:0] COEF = 16'h7AE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic [15:0] din,
  input  logic        frame_start,
`ifdef PREEM_COEF_PROG_EN
  input  logic        coef_load,
  input  logic [15:0] coef_in,
`endif
  output logic        dout_valid,
  output logic [15:0] dout_cur,
  output logic [16:0] dout_scaled
);

  // Streaming handshake: din_valid marks a sample for one cycle and is always
  // accepted; dout_valid is a one-cycle pulse per sample with no ready, so the
  // consumer must take dout_cur/dout_scaled in the cycle dout_valid is high.

  logic [15:0] x_cur_q, x_cur_d;
  logic [15:0] x_prev_q, x_prev_d;
  logic [15:0] hist_q, hist_d;
  logic        v1_q, v1_d;

  logic        dout_valid_q, dout_valid_d;
  logic [15:0] dout_cur_q, dout_cur_d;
  logic [16:0] dout_scaled_q, dout_scaled_d;

  logic [15:0]        coef_use;
  logic signed [31:0] prod;
  logic signed [31:0] prod_rnd;
  logic [14:0]        rnd_unused;

`ifdef PREEM_COEF_PROG_EN
  logic [15:0] coef_q, coef_d;

  always_comb begin
    coef_d = coef_q;
    if (coef_load) coef_d = coef_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coef_q <= COEF;
    else     coef_q <= coef_d;
  end

  assign coef_use = coef_q;
`else
  assign coef_use = COEF;
`endif

  // Stage 1: capture sample and its predecessor; frame_start clears history.
  always_comb begin
    x_cur_d  = x_cur_q;
    x_prev_d = x_prev_q;
    hist_d   = hist_q;
    v1_d     = din_valid;
    if (din_valid) begin
      x_cur_d  = din;
      x_prev_d = frame_start ? 16'h0000 : hist_q;
      hist_d   = din;
    end else if (frame_start) begin
      hist_d = 16'h0000;
    end
  end

  // Stage 2: signed Q1.15 product, round half toward +inf at bit 14.
  always_comb begin
    prod          = $signed(x_prev_q) * $signed(coef_use);
    prod_rnd      = prod + 32'sd16384;
    rnd_unused    = prod_rnd[14:0];
    dout_valid_d  = v1_q;
    dout_cur_d    = dout_cur_q;
    dout_scaled_d = dout_scaled_q;
    if (v1_q) begin
      dout_cur_d    = x_cur_q;
      dout_scaled_d = prod_rnd[31:15];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cur_q       <= '0;
      x_prev_q      <= '0;
      hist_q        <= '0;
      v1_q          <= 1'b0;
      dout_valid_q  <= 1'b0;
      dout_cur_q    <= '0;
      dout_scaled_q <= '0;
    end else begin
      x_cur_q       <= x_cur_d;
      x_prev_q      <= x_prev_d;
      hist_q        <= hist_d;
      v1_q          <= v1_d;
      dout_valid_q  <= dout_valid_d;
      dout_cur_q    <= dout_cur_d;
      dout_scaled_q <= dout_scaled_d;
    end
  end

  assign dout_valid  = dout_valid_q;
  assign dout_cur    = dout_cur_q;
  assign dout_scaled = dout_scaled_q;

endmodule

`default_nettype wire

// File: tb/tb_preem_delay_mult.sv
// Bench for preem_delay_mult: two instances (a = 0.5, b = -1.0) share stimulus,
// a queue-based scoreboard is checked by an independent negedge monitor.
module tb_preem_delay_mult;

  localparam logic [15:0] COEF_A = 16'h4000;
  localparam logic [15:0] COEF_B = 16'h8000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic [15:0] din = '0;
  logic        frame_start = 1'b0;
  logic        coef_load = 1'b0;
  logic [15:0] coef_in = '0;

  logic        dout_valid_a, dout_valid_b;
  logic [15:0] dout_cur_a, dout_cur_b;
  logic [16:0] dout_scaled_a, dout_scaled_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Entry: {due_cycle[31:0], cur[15:0], scaled_a[16:0], scaled_b[16:0]}
  logic [81:0] exp_q[$];

  int m_hist = 0;
  int m_coef_a = int'($signed(COEF_A));
  int m_coef_b = int'($signed(COEF_B));

  preem_delay_mult #(.COEF(COEF_A)) dut_a (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .frame_start(frame_start),
`ifdef PREEM_COEF_PROG_EN
    .coef_load(coef_load), .coef_in(coef_in),
`endif
    .dout_valid(dout_valid_a), .dout_cur(dout_cur_a), .dout_scaled(dout_scaled_a)
  );

  preem_delay_mult #(.COEF(COEF_B)) dut_b (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .frame_start(frame_start),
`ifdef PREEM_COEF_PROG_EN
    .coef_load(coef_load), .coef_in(coef_in),
`endif
    .dout_valid(dout_valid_b), .dout_cur(dout_cur_b), .dout_scaled(dout_scaled_b)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // round(x*c/2^15) with ties toward +inf, done as a floor division on integers.
  function automatic logic [16:0] ref_scaled(input int xp, input int c);
    longint n;
    longint q;
    n = longint'(xp) * longint'(c) + 64'sd16384;
    q = n / 64'sd32768;
    if ((n % 64'sd32768) != 0 && n < 0) q = q - 1;
    return q[16:0];
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
    end
  endtask

  // Driver: present one cycle of inputs and update the reference model.
  task automatic step(input logic v, input logic fs, input logic [15:0] d,
                      input logic ld = 1'b0, input logic [15:0] ci = 16'h0000);
    int prev;
    logic [31:0] due;
    @(posedge clk);
    #1;
    din_valid   = v;
    frame_start = fs;
    din         = d;
    coef_load   = ld;
    coef_in     = ci;
`ifdef PREEM_COEF_PROG_EN
    if (ld) begin
      m_coef_a = int'($signed(ci));
      m_coef_b = int'($signed(ci));
    end
`endif
    if (v) begin
      prev = fs ? 0 : m_hist;
      due  = 32'(cyc + 2);
      exp_q.push_back({due, d, ref_scaled(prev, m_coef_a), ref_scaled(prev, m_coef_b)});
      m_hist = int'($signed(d));
    end else if (fs) begin
      m_hist = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000);
  endtask

  // Reset mid-stream: everything in flight is dropped, outputs clear at once.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    din_valid = 1'b0;
    frame_start = 1'b0;
    coef_load = 1'b0;
    exp_q.delete();
    m_hist = 0;
    m_coef_a = int'($signed(COEF_A));
    m_coef_b = int'($signed(COEF_B));
    #1;
    chk("rst_valid_a", longint'(dout_valid_a), 0);
    chk("rst_cur_a", longint'(dout_cur_a), 0);
    chk("rst_scaled_a", longint'(dout_scaled_a), 0);
    chk("rst_valid_b", longint'(dout_valid_b), 0);
    chk("rst_scaled_b", longint'(dout_scaled_b), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [81:0] e;
    if (!rst) begin
      if (exp_q.size() != 0 && exp_q[0][81:50] == 32'(cyc)) begin
        e = exp_q.pop_front();
        chk("valid_a", longint'(dout_valid_a), 1);
        chk("valid_b", longint'(dout_valid_b), 1);
        chk("cur_a", longint'($signed(dout_cur_a)), longint'($signed(e[49:34])));
        chk("cur_b", longint'($signed(dout_cur_b)), longint'($signed(e[49:34])));
        chk("scaled_a", longint'($signed(dout_scaled_a)), longint'($signed(e[33:17])));
        chk("scaled_b", longint'($signed(dout_scaled_b)), longint'($signed(e[16:0])));
      end else begin
        chk("no_spurious_a", longint'(dout_valid_a), 0);
        chk("no_spurious_b", longint'(dout_valid_b), 0);
      end
    end
  end

  initial begin
    logic v, fs;
    logic [15:0] d;
    int sel;
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", longint'(dout_valid_a), 0);
    chk("init_cur", longint'(dout_cur_a), 0);
    chk("init_scaled", longint'(dout_scaled_b), 0);
    rst = 1'b0;

    // Back-to-back after reset: (100,0),(200,50),(300,100)
    step(1, 0, 16'd100); step(1, 0, 16'd200); step(1, 0, 16'd300);
    idle(3);
    // History survives idle gaps
    step(1, 0, 16'd1000); idle(5); step(1, 0, 16'd7);
    idle(3);
    // frame_start with a sample, then continuing
    step(1, 0, 16'd400); step(1, 0, 16'd800); step(1, 1, 16'd600); step(1, 0, 16'd10);
    idle(3);
    // frame_start while idle
    step(1, 0, 16'd77); step(0, 1, 16'd0); step(1, 0, 16'd5);
    idle(3);
    // Rounding ties and extremes
    step(1, 0, -16'sd3); step(1, 0, 16'd0); step(1, 0, 16'd3); step(1, 0, 16'd0);
    step(1, 0, 16'h8000); step(1, 0, 16'd0); step(1, 0, 16'h7FFF); step(1, 0, 16'hFFFF);
    step(1, 0, 16'd1);
    idle(3);
    // Reset with samples in flight, then first sample sees zero history
    step(1, 0, 16'd1234); step(1, 0, -16'sd555);
    do_reset();
    idle(3);
    step(1, 0, 16'd50); step(1, 0, 16'd60);
    idle(3);
`ifdef PREEM_COEF_PROG_EN
    step(0, 0, 16'd0, 1'b1, 16'h2000);
    step(1, 0, 16'd800); step(1, 0, 16'd800);
    idle(2);
    step(1, 0, 16'd100, 1'b1, 16'h6000); step(1, 0, 16'd900);
    idle(2);
    do_reset();
    step(1, 0, 16'd800); step(1, 0, 16'd800);
    idle(3);
`endif

    // Randomized traffic with extreme values mixed in
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      fs  = ($urandom_range(0, 15) == 0);
      sel = $urandom_range(0, 7);
      case (sel)
        0: d = 16'h8000;
        1: d = 16'h7FFF;
        2: d = 16'hFFFF;
        default: d = 16'($urandom);
      endcase
`ifdef PREEM_COEF_PROG_EN
      if ($urandom_range(0, 31) == 0) step(v, fs, d, 1'b1, 16'($urandom));
      else step(v, fs, d);
`else
      step(v, fs, d);
`endif
    end

    idle(1);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain", longint'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
